axis_matrix_tx: RTL and testbench

- AXI4-Stream transmitter for the QR-CORDIC result path inside yolo_top.
- Collects one result matrix of NUM_COL column words from the CORDIC core through a valid/ready load port, then streams them out on the M_AXIS_S2MM master interface.
- Drives TLAST on the final beat, holds TKEEP all-ones, and fully honours downstream backpressure.
- It is the sending end of the stream that the DMA/testbench receives on S2MM.

---
 rtl/qr_cordic_pkg.sv | 19 +
 rtl/axis_matrix_tx.sv | 132 +++++++++++++
 tb/tb_axis_matrix_tx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qr_cordic_pkg.sv
// Shared definitions for the QR-CORDIC result path: default widths, the
// transmitter state encoding and the pointer width helper.
package qr_cordic_pkg;

    localparam int unsigned TBITS_DEF   = 64;
    localparam int unsigned TBYTE_DEF   = 8;
    localparam int unsigned NUM_COL_DEF = 8;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_e;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_matrix_tx.sv
// Buffers one NUM_COL-word result matrix from the CORDIC core and streams it
// out on an AXI4-Stream master with TLAST on the final column.
module axis_matrix_tx
    import qr_cordic_pkg::*;
#(
    parameter int unsigned TBITS   = TBITS_DEF,
    parameter int unsigned TBYTE   = TBYTE_DEF,
    parameter int unsigned NUM_COL = NUM_COL_DEF
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [TBITS-1:0] res_data,
    output logic             M_AXIS_S2MM_TVALID,
    input  logic             M_AXIS_S2MM_TREADY,
    output logic [TBITS-1:0] M_AXIS_S2MM_TDATA,
    output logic [TBYTE-1:0] M_AXIS_S2MM_TKEEP,
    output logic             M_AXIS_S2MM_TLAST,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned   PW       = ptr_width(NUM_COL);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_COL - 1);

    tx_state_e        state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    rd_nxt;
    logic [TBITS-1:0] mem_q [NUM_COL];
    logic [TBITS-1:0] mem_d [NUM_COL];
    logic             tvalid_q, tvalid_d;
    logic [TBITS-1:0] tdata_q, tdata_d;
    logic [TBYTE-1:0] tkeep_q, tkeep_d;
    logic             tlast_q, tlast_d;
    logic             ready_q, ready_d;
    logic             load_acc;
    logic             beat_acc;

    assign load_acc = res_valid && ready_q;
    assign beat_acc = tvalid_q && M_AXIS_S2MM_TREADY;
    assign rd_nxt   = rd_ptr_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        unique case (state_q)
            FILL: begin
                if (load_acc) begin
                    mem_d[wr_ptr_q] = res_data;
                    if (wr_ptr_q == LAST_IDX) begin
                        // Column 0 was stored on an earlier edge, so it can be
                        // presented straight from the buffer.
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        state_d  = SEND;
                        tvalid_d = 1'b1;
                        tdata_d  = mem_q[0];
                        tkeep_d  = '1;
                        tlast_d  = 1'b0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (beat_acc) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tkeep_d  = '0;
                        state_d  = DONE;
                    end else begin
                        rd_ptr_d = rd_nxt;
                        tdata_d  = mem_q[rd_nxt];
                        tlast_d  = (rd_nxt == LAST_IDX);
                    end
                end
            end
            DONE: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
        // Registered so res_ready stays low while reset is asserted.
        ready_d = (state_d == FILL);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

    assign res_ready          = ready_q;
    assign M_AXIS_S2MM_TVALID = tvalid_q;
    assign M_AXIS_S2MM_TDATA  = tdata_q;
    assign M_AXIS_S2MM_TKEEP  = tkeep_q;
    assign M_AXIS_S2MM_TLAST  = tlast_q;
    assign busy               = (state_q == SEND);
    assign frame_done         = (state_q == DONE);

endmodule

// File: tb/tb_axis_matrix_tx.sv
// Self-checking bench for axis_matrix_tx: randomized load/backpressure traffic
// compared against a word-count model of the frame protocol.
module tb_axis_matrix_tx;

    localparam int N = 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [63:0] res_data = '0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        busy;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] src_q[$];

    axis_matrix_tx #(
        .TBITS   (64),
        .TBYTE   (8),
        .NUM_COL (N)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_data           (res_data),
        .M_AXIS_S2MM_TVALID (tvalid),
        .M_AXIS_S2MM_TREADY (tready),
        .M_AXIS_S2MM_TDATA  (tdata),
        .M_AXIS_S2MM_TKEEP  (tkeep),
        .M_AXIS_S2MM_TLAST  (tlast),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Model: a frame is fully loaded when the accepted-word count is a multiple
    // of N and ahead of the sent-beat count; beats must replay src_q in order.
    // vmode: 0 continuous, 1 every 3rd cycle, 2 random.
    // rmode: 0 always ready, 1 pattern 1,0,0,1,0,1, 2 random, 3 stall 20 on last.
    task automatic run_frames(input string name, input int vmode, input int rmode);
        int          load_idx = 0;
        int          beat_idx = 0;
        int          cyc = 0;
        int          tail = 0;
        int          stall = 0;
        int          total = src_q.size();
        bit          done_exp = 0;
        bit          exp_tv, exp_rdy, acc, beat;
        logic [5:0]  pat = 6'b101001;
        while (tail < 2) begin
            exp_tv  = (load_idx > beat_idx) && (load_idx % N == 0);
            exp_rdy = !exp_tv && !done_exp;
            case (vmode)
                0:       res_valid = (load_idx < total);
                1:       res_valid = (load_idx < total) && (cyc % 3 == 2);
                default: res_valid = (load_idx < total) && ($urandom_range(1, 0) == 1);
            endcase
            res_data = (load_idx < total) ? src_q[load_idx] : {$urandom, $urandom};
            case (rmode)
                0: tready = 1'b1;
                1: tready = pat[cyc % 6];
                2: tready = ($urandom_range(1, 0) == 1);
                default: begin
                    if (exp_tv && (beat_idx % N == N - 1) && stall < 20) begin
                        tready = 1'b0;
                        stall++;
                    end else begin
                        tready = 1'b1;
                    end
                end
            endcase
            n_cmp++;
            if (frame_done !== done_exp) begin
                n_fail++;
                $display("FAIL %s frame_done cyc=%0d got=%b exp=%b", name, cyc, frame_done, done_exp);
            end
            n_cmp++;
            if (tvalid !== exp_tv) begin
                n_fail++;
                $display("FAIL %s tvalid cyc=%0d got=%b exp=%b", name, cyc, tvalid, exp_tv);
            end
            n_cmp++;
            if (busy !== exp_tv) begin
                n_fail++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, busy, exp_tv);
            end
            n_cmp++;
            if (res_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s res_ready cyc=%0d got=%b exp=%b", name, cyc, res_ready, exp_rdy);
            end
            n_cmp++;
            if (tkeep !== (exp_tv ? 8'hFF : 8'h00)) begin
                n_fail++;
                $display("FAIL %s tkeep cyc=%0d got=%h exp_valid=%b", name, cyc, tkeep, exp_tv);
            end
            if (exp_tv) begin
                n_cmp++;
                if (tdata !== src_q[beat_idx]) begin
                    n_fail++;
                    $display("FAIL %s tdata beat=%0d got=%h exp=%h", name, beat_idx, tdata,
                             src_q[beat_idx]);
                end
                n_cmp++;
                if (tlast !== (beat_idx % N == N - 1)) begin
                    n_fail++;
                    $display("FAIL %s tlast beat=%0d got=%b", name, beat_idx, tlast);
                end
            end else begin
                n_cmp++;
                if (tlast !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s tlast_idle cyc=%0d got=%b exp=0", name, cyc, tlast);
                end
            end
            acc      = res_valid && exp_rdy;
            beat     = exp_tv && tready;
            done_exp = beat && (beat_idx % N == N - 1);
            if (acc) load_idx++;
            if (beat) beat_idx++;
            if (beat_idx == total && !beat) tail++;
            cyc++;
            if (cyc > 3000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s timeout got beats=%0d exp=%0d", name, beat_idx, total);
                break;
            end
            step();
        end
        res_valid = 1'b0;
        tready    = 1'b0;
    endtask

    task automatic test_reset();
        aresetn   = 1'b0;
        tready    = 1'b1;
        res_valid = 1'b1;
        res_data  = {$urandom, $urandom};
        step();
        step();
        n_cmp++;
        if ({res_ready, tvalid, tlast, tkeep, tdata, busy, frame_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b tv=%b tl=%b tk=%h td=%h busy=%b fd=%b exp all 0",
                     res_ready, tvalid, tlast, tkeep, tdata, busy, frame_done);
        end
        res_valid = 1'b0;
        tready    = 1'b0;
        aresetn   = 1'b1;
        step();
        n_cmp++;
        if (res_ready !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got rdy=%b tv=%b busy=%b exp 1/0/0", res_ready, tvalid, busy);
        end
    endtask

    task automatic test_basic();
        src_q.delete();
        for (int i = 0; i < N; i++) src_q.push_back(64'(i + 1));
        run_frames("basic", 0, 0);
    endtask

    task automatic test_backpressure();
        src_q.delete();
        for (int i = 0; i < N; i++) src_q.push_back({$urandom, $urandom});
        run_frames("backpressure", 0, 1);
    endtask

    task automatic test_gapped_load();
        src_q.delete();
        for (int i = 0; i < N; i++) src_q.push_back({$urandom, $urandom});
        run_frames("gapped", 1, 0);
    endtask

    task automatic test_back_to_back();
        src_q.delete();
        for (int i = 0; i < N; i++) src_q.push_back(64'(8'hA0 + i));
        for (int i = 0; i < N; i++) src_q.push_back(64'(8'hB0 + i));
        run_frames("back_to_back", 0, 0);
    endtask

    task automatic test_random_traffic();
        src_q.delete();
        for (int i = 0; i < 3 * N; i++) src_q.push_back({$urandom, $urandom});
        run_frames("random", 2, 2);
    endtask

    task automatic test_stall_last();
        src_q.delete();
        for (int i = 0; i < N; i++) src_q.push_back({$urandom, $urandom});
        run_frames("stall_last", 0, 3);
    endtask

    task automatic test_reset_mid_send();
        logic [63:0] w[N];
        for (int i = 0; i < N; i++) w[i] = {$urandom, $urandom};
        n_cmp++;
        if (res_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_send_pre_ready got=%b exp=1", res_ready);
        end
        tready    = 1'b0;
        res_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            res_data = w[i];
            step();
        end
        res_valid = 1'b0;
        tready    = 1'b1;
        step();
        step();
        step();
        tready = 1'b0;
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== w[3]) begin
            n_fail++;
            $display("FAIL mid_send_beat4 got tv=%b td=%h exp tv=1 td=%h", tvalid, tdata, w[3]);
        end
        step();
        #2;
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tkeep !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_send_async_reset got tv=%b tl=%b tk=%h busy=%b exp 0/0/00/0",
                     tvalid, tlast, tkeep, busy);
        end
        step();
        n_cmp++;
        if (res_ready !== 1'b0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_send_held_reset got rdy=%b tv=%b exp 0/0", res_ready, tvalid);
        end
        aresetn = 1'b1;
        step();
        n_cmp++;
        if (res_ready !== 1'b1 || tvalid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_send_release got rdy=%b tv=%b fd=%b exp 1/0/0",
                     res_ready, tvalid, frame_done);
        end
        src_q.delete();
        for (int i = 0; i < N; i++) src_q.push_back({$urandom, $urandom});
        run_frames("post_reset", 0, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped_load();
        test_back_to_back();
        test_random_traffic();
        test_stall_last();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
